array_inside_scanner: RTL and testbench
=======================================

Name: array_inside_scanner

Overview:
- Read-side companion to the sequential array writer: holds a DEPTH-entry table filled at a wrapping write pointer.
- Answers "key inside {table}" membership queries by scanning the table one entry per clock.
- Returns hit flag, first matching index and match count over a valid/ready response channel.
- Sits beside the writer in debug/trace paths, replacing single-cycle combinational inside checks with a timed, verifiable scan.

Parameters:
- DATA_W, 8, entry and key width in bits
- DEPTH, 16, table entries; power of two, at least 2
- AW, $clog2(DEPTH), index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write wr_data at write pointer
- wr_data  in  DATA_W  table write data
- wr_drop  out  1  one-cycle pulse: write ignored because busy
- req_valid  in  1  query request valid
- req_ready  out  1  scanner can accept a query
- req_key  in  DATA_W  value to search
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_hit  out  1  at least one match
- rsp_index  out  AW  lowest matching index; 0 on miss
- rsp_count  out  AW+1  number of matching entries
- fill  out  AW+1  valid entries, saturates at DEPTH
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: fill=0, write pointer=0, state IDLE, req_ready=1, rsp_valid=0, rsp_hit=0, rsp_index=0, rsp_count=0, wr_drop=0, busy=0. Table contents are not reset; entries at index >= fill are never compared.
- Writes:
  - In IDLE, wr_en writes mem[wptr], then wptr <= wptr+1 (wraps DEPTH-1 -> 0) and fill <= min(fill+1, DEPTH).
  - Once fill = DEPTH, a write overwrites the oldest entry by index.
  - In SCAN or RESP, wr_en is ignored and wr_drop pulses high the next cycle. Table, wptr and fill are unchanged.
- State machine: IDLE -> SCAN -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready at cycle T: latch the key, capture N=fill, clear the accumulators, set scan_idx=0.
  - If N=0, go directly to RESP; rsp_valid=1 at T+1 with hit=0, count=0.
  - Otherwise go to SCAN.
  - If wr_en and a request coincide in IDLE, both happen. N is captured before the write, so the new entry is not searched.
- SCAN:
  - req_ready=0.
  - In cycle T+1+i, compare mem[i] with the key. On equality: count+1; on the first hit, record index=i.
  - After i=N-1, go to RESP. rsp_valid rises at T+1+N, so a full 16-entry scan responds at T+17.
- RESP:
  - rsp_valid=1. rsp_hit, rsp_index and rsp_count are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready, return to IDLE; req_ready=1 the next cycle.
  - No back-to-back acceptance in the same cycle as the response handshake.
- Arithmetic: count width AW+1, so it holds up to DEPTH without overflow. Index compare is an exact DATA_W-bit equality.
- Reset mid-operation: rst in any state returns to the reset values next cycle. Any pending response is discarded and fill returns to 0.
- req_key is sampled only at acceptance; later changes have no effect.

Optional Feature:
- Macro INSIDE_SCAN_EARLY_EXIT_EN.
- Defined:
  - SCAN ends at the first match at index k; rsp_valid at T+2+k with hit=1, index=k, count=1.
  - Misses behave as in the full scan (rsp at T+1+N, count=0).
- Undefined:
  - Full scan always runs.
  - rsp_count is the exact total number of matches.

Test Plan:
- Reset, then req_key=8'd0 with fill=0 -> rsp_valid at T+1, hit=0, index=0, count=0.
- Write 16 entries i*5 (0..75), then key=15 -> hit=1, index=3, count=1. rsp at T+17 (T+5 with INSIDE_SCAN_EARLY_EXIT_EN).
- Same table, key=16 -> hit=0, index=0, count=0, rsp at T+17. Then write 4 more values 80, 85, 90, 95: wptr wraps, fill stays 16, key=0 -> miss, key=85 -> hit, index=1.
- Table of 16 copies of 8'd20, key=20 -> hit=1, index=0, count=16 (EARLY_EXIT: count=1, rsp at T+2).
- Hold rsp_ready=0 for 3 cycles after rsp_valid -> outputs stable, req_ready=0. A wr_en issued during SCAN -> wr_drop pulse, fill unchanged.
- Assert rst at cycle T+5 of a 16-entry scan -> next cycle IDLE, rsp_valid=0, fill=0, req_ready=1.

Source files
------------

// File: rtl/array_inside_scanner.sv
// DEPTH-entry table with a wrapping write pointer; answers "key inside {table}" by scanning one entry per clock.
// Optional: define INSIDE_SCAN_EARLY_EXIT_EN to end the scan at the first match.
module array_inside_scanner #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_key,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [AW-1:0]     rsp_index,
  output logic [AW:0]       rsp_count,
  output logic [AW:0]       fill,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW:0]       r_fill;
  logic [DATA_W-1:0] r_key;
  logic [AW:0]       r_n;
  logic [AW-1:0]     r_idx;
  logic              r_hit;
  logic [AW-1:0]     r_index;
  logic [AW:0]       r_count;
  logic              r_wr_drop;

  logic w_accept, w_wr, w_match, w_last, w_done;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_wr     = (r_state == S_IDLE) && wr_en;
  assign w_match  = (r_mem[r_idx] == r_key);
  assign w_last   = ({1'b0, r_idx} == (r_n - {{AW{1'b0}}, 1'b1}));
`ifdef INSIDE_SCAN_EARLY_EXIT_EN
  assign w_done   = w_last || w_match;
`else
  assign w_done   = w_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = (r_fill == '0) ? S_RESP : S_SCAN;
      S_SCAN:  if (w_done)    w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE:  begin req_ready = 1'b1; busy = 1'b0; end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Table storage is deliberately not reset; entries at or above fill are never compared.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_fill    <= '0;
      r_key     <= '0;
      r_n       <= '0;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      r_index   <= '0;
      r_count   <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= wr_en && (r_state != S_IDLE);
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
        if (r_fill != (AW+1)'(DEPTH)) r_fill <= r_fill + 1'b1;
      end
      // N is captured from the pre-write fill, so a coincident write is not searched.
      if (w_accept) begin
        r_key   <= req_key;
        r_n     <= r_fill;
        r_idx   <= '0;
        r_hit   <= 1'b0;
        r_index <= '0;
        r_count <= '0;
      end else if (r_state == S_SCAN) begin
        r_idx <= r_idx + 1'b1;
        if (w_match) begin
          r_count <= r_count + 1'b1;
          r_hit   <= 1'b1;
          if (!r_hit) r_index <= r_idx;
        end
      end
    end
  end

  assign wr_drop   = r_wr_drop;
  assign rsp_hit   = r_hit;
  assign rsp_index = r_index;
  assign rsp_count = r_count;
  assign fill      = r_fill;

endmodule

// File: tb/tb_array_inside_scanner.sv
// Randomized self-checking bench for array_inside_scanner against a queue-free array model of the table.
module tb_array_inside_scanner;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_drop;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DATA_W-1:0] req_key = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_hit;
  logic [AW-1:0]     rsp_index;
  logic [AW:0]       rsp_count;
  logic [AW:0]       fill;
  logic              busy;

  array_inside_scanner #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_drop(wr_drop),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_index(rsp_index), .rsp_count(rsp_count), .fill(fill), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: table contents, oldest-overwrite pointer and fill level.
  int m_mem [DEPTH];
  int m_wptr = 0;
  int m_fill = 0;

  function automatic void m_write(input int v);
    m_mem[m_wptr] = v;
    m_wptr = (m_wptr + 1) % DEPTH;
    if (m_fill < DEPTH) m_fill++;
  endfunction

  // Expected response and latency (cycles from acceptance to rsp_valid) from membership rules.
  function automatic void m_query(input int key, output int lat, output int hit, output int idx, output int cnt);
    int first = -1;
    int total = 0;
    for (int i = 0; i < m_fill; i++)
      if (m_mem[i] == key) begin
        total++;
        if (first < 0) first = i;
      end
    hit = (total > 0);
    idx = (first < 0) ? 0 : first;
`ifdef INSIDE_SCAN_EARLY_EXIT_EN
    cnt = hit ? 1 : 0;
    lat = hit ? first + 2 : m_fill + 1;
`else
    cnt = total;
    lat = m_fill + 1;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    m_wptr = 0;
    m_fill = 0;
  endtask

  task automatic do_write(input int v);
    @(negedge clk) begin wr_en = 1'b1; wr_data = v[DATA_W-1:0]; end
    @(posedge clk);
    #1 wr_en = 1'b0;
    m_write(v);
  endtask

  // Issue a request, wait (bounded) for rsp_valid, hold rsp_ready low for hold cycles, then handshake.
  task automatic do_query(input int key, input int hold, output int lat, output int hit, output int idx, output int cnt);
    @(negedge clk) begin req_valid = 1'b1; req_key = key[DATA_W-1:0]; end
    @(posedge clk);
    #1 begin req_valid = 1'b0; req_key = $urandom; end
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = 0;
    hit = rsp_hit;
    idx = rsp_index;
    cnt = rsp_count;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, req_ready, rsp_hit, 32'(rsp_index), 32'(rsp_count)} !== {1'b1, 1'b0, hit[0], idx, cnt})
        $display("FAIL hold_stable cyc%0d: got v=%0b rdy=%0b hit=%0b idx=%0d cnt=%0d want v=1 rdy=0 hit=%0d idx=%0d cnt=%0d",
                 h, rsp_valid, req_ready, rsp_hit, rsp_index, rsp_count, hit, idx, cnt);
      else n_pass++;
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic check_query(input string name, input int key);
    int lat, hit, idx, cnt, elat, ehit, eidx, ecnt;
    m_query(key, elat, ehit, eidx, ecnt);
    do_query(key, 0, lat, hit, idx, cnt);
    n_checks++;
    if ({lat, hit, idx, cnt} !== {elat, ehit, eidx, ecnt})
      $display("FAIL %s key=%0d: got lat=%0d hit=%0d idx=%0d cnt=%0d want lat=%0d hit=%0d idx=%0d cnt=%0d",
               name, key, lat, hit, idx, cnt, elat, ehit, eidx, ecnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({req_ready, rsp_valid, rsp_hit, rsp_index, rsp_count, fill, busy, wr_drop} !==
        {1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, 1'b0})
      $display("FAIL reset_state: got rdy=%0b v=%0b hit=%0b idx=%0d cnt=%0d fill=%0d busy=%0b drop=%0b want 1 0 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_hit, rsp_index, rsp_count, fill, busy, wr_drop);
    else n_pass++;
    check_query("empty_table", 0);
  endtask

  task automatic test_ramp();
    for (int i = 0; i < DEPTH; i++) do_write(i * 5);
    check_query("ramp_hit", 15);
    check_query("ramp_miss", 16);
    for (int i = 0; i < 4; i++) do_write(80 + i * 5);
    @(negedge clk);
    n_checks++;
    if (int'(fill) !== DEPTH) $display("FAIL fill_saturate: got %0d want %0d", fill, DEPTH);
    else n_pass++;
    check_query("wrap_miss0", 0);
    check_query("wrap_hit85", 85);
  endtask

  task automatic test_duplicates();
    for (int i = 0; i < DEPTH; i++) do_write(20);
    check_query("dup_all", 20);
  endtask

  task automatic test_drop_and_hold();
    int lat, hit, idx, cnt, elat, ehit, eidx, ecnt;
    m_query(21, elat, ehit, eidx, ecnt);
    @(negedge clk) begin req_valid = 1'b1; req_key = 8'd21; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk) begin wr_en = 1'b1; wr_data = 8'd21; end
    @(posedge clk);
    #1 wr_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({wr_drop, fill} !== {1'b1, 5'd16}) $display("FAIL wr_drop_pulse: got drop=%0b fill=%0d want 1 16", wr_drop, fill);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (wr_drop !== 1'b0) $display("FAIL wr_drop_clear: got %0b want 0", wr_drop);
    else n_pass++;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    n_checks++;
    if ({rsp_valid, rsp_hit, 32'(rsp_count)} !== {1'b1, 1'b0, ecnt})
      $display("FAIL dropped_not_searched: got v=%0b hit=%0b cnt=%0d want v=1 hit=0 cnt=%0d", rsp_valid, rsp_hit, rsp_count, ecnt);
    else n_pass++;
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    m_query(20, elat, ehit, eidx, ecnt);
    do_query(20, 3, lat, hit, idx, cnt);
    n_checks++;
    if ({lat, hit, idx, cnt} !== {elat, ehit, eidx, ecnt})
      $display("FAIL hold_result: got lat=%0d hit=%0d idx=%0d cnt=%0d want lat=%0d hit=%0d idx=%0d cnt=%0d",
               lat, hit, idx, cnt, elat, ehit, eidx, ecnt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL after_handshake: got rdy=%0b v=%0b want 1 0", req_ready, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int nw;
      if ($urandom_range(0, 4) == 0) do_reset();
      nw = $urandom_range(0, 20);
      for (int w = 0; w < nw; w++) do_write($urandom_range(0, 7));
      check_query("random", $urandom_range(0, 8));
    end
  endtask

  task automatic test_reset_mid();
    while (m_fill < DEPTH) do_write($urandom_range(0, 7));
    @(negedge clk) begin req_valid = 1'b1; req_key = 8'd200; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_wptr = 0;
    m_fill = 0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, fill, busy} !== {1'b1, 1'b0, 5'd0, 1'b0})
      $display("FAIL reset_mid_scan: got rdy=%0b v=%0b fill=%0d busy=%0b want 1 0 0 0", req_ready, rsp_valid, fill, busy);
    else n_pass++;
    check_query("post_reset_empty", 200);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_duplicates();
    test_drop_and_hold();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
